motion_mask: RTL and testbench

Downstream stage of the per-pixel sigma-delta background/variance update. Consumes the same pixel stream (current pixel, stored background, stored variance) and produces a binary motion mask bit per pixel. It also accumulates per-frame motion statistics and raises a frame-level motion flag. Output feeds the mask writer and the alarm/controller logic.

---
 rtl/motion_pkg.sv | 22 ++
 rtl/motion_mask_if.sv | 31 +++
 rtl/abs_diff_thr.sv | 29 ++
 rtl/motion_mask.sv | 131 +++++++++++++
 tb/tb_motion_mask.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared types and default geometry for the motion detection pixel path.
// Also provides the counter-width helper used to size per-frame pixel counts.
package motion_pkg;

    typedef logic [7:0] pix_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int DEF_FRAME_W = 640;
    localparam int DEF_FRAME_H = 480;

    // variance * N_FACTOR (N_FACTOR <= 4) always fits in 10 bits
    localparam int THR_W = 10;

    function automatic int cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/motion_mask_if.sv
// Pixel-in / mask-and-statistics-out bundle for motion_mask.
// The master side is the pixel source; the slave side is the mask block.
interface motion_mask_if #(
    parameter int CNT_W = motion_pkg::cnt_width(motion_pkg::DEF_FRAME_W, motion_pkg::DEF_FRAME_H)
);
    import motion_pkg::*;

    logic             enable;
    logic             in_valid;
    logic             in_sof;
    pix_t             curr_pixel;
    pix_t             background;
    pix_t             variance;
    logic             mask_valid;
    logic             mask_bit;
    logic             frame_done;
    logic [CNT_W-1:0] motion_count;
    logic             motion_detected;
    logic             frame_err;

    modport master (
        output enable, in_valid, in_sof, curr_pixel, background, variance,
        input  mask_valid, mask_bit, frame_done, motion_count, motion_detected, frame_err
    );

    modport slave (
        input  enable, in_valid, in_sof, curr_pixel, background, variance,
        output mask_valid, mask_bit, frame_done, motion_count, motion_detected, frame_err
    );

endinterface

// File: rtl/abs_diff_thr.sv
// Stage 1 of the mask pipeline: registers |curr - background| and variance * N_FACTOR.
// Registers only load on accepted pixels and otherwise hold.
module abs_diff_thr
    import motion_pkg::*;
#(
    parameter int N_FACTOR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  pix_t             curr_pixel,
    input  pix_t             background,
    input  pix_t             variance,
    output pix_t             diff,
    output logic [THR_W-1:0] thr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            thr  <= '0;
        end else if (load) begin
            diff <= (curr_pixel >= background) ? (curr_pixel - background)
                                               : (background - curr_pixel);
            thr  <= THR_W'(variance) * THR_W'(N_FACTOR);
        end
    end

endmodule

// File: rtl/motion_mask.sv
// Per-pixel motion mask (|curr-bg| > N*var) with per-frame motion counting,
// short-frame detection and suppression of the first INIT_FRAMES frames.
module motion_mask
    import motion_pkg::*;
#(
    parameter int N_FACTOR    = 2,
    parameter int FRAME_W     = DEF_FRAME_W,
    parameter int FRAME_H     = DEF_FRAME_H,
    parameter int MIN_MOTION  = 64,
    parameter int INIT_FRAMES = 1
) (
    input  logic          clk,
    input  logic          rst,
    motion_mask_if.slave  bus
);

    localparam int TOTAL  = FRAME_W * FRAME_H;
    localparam int CNT_W  = cnt_width(FRAME_W, FRAME_H);
    localparam int INIT_W = (INIT_FRAMES > 0) ? $clog2(INIT_FRAMES + 1) : 1;

    state_t             state;
    logic [CNT_W-1:0]   pix_cnt;
    logic [INIT_W-1:0]  init_cnt;
    logic               err_q;

    logic               accept, start, take, last_pix, in_init;

    logic [1:0]         vld_pipe;
    logic               s1_first, s1_last, s1_sup;
    logic               s2_first, s2_last;
    pix_t               diff;
    logic [THR_W-1:0]   thr;
    logic               mask_q;

    logic [CNT_W-1:0]   acc, nacc, count_q;
    logic               det_q, done_q;

    // Any accepted SOF starts a frame; in ACTIVE it also aborts the current one.
    assign accept   = bus.enable && bus.in_valid;
    assign start    = accept && bus.in_sof;
    assign take     = start || (accept && state == ACTIVE);
    assign last_pix = take && !start && (pix_cnt == CNT_W'(TOTAL - 1));
    assign in_init  = init_cnt < INIT_W'(INIT_FRAMES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            init_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (start) begin
                err_q   <= (state == ACTIVE);
                state   <= ACTIVE;
                pix_cnt <= CNT_W'(1);
            end else if (take) begin
                if (last_pix) begin
                    state   <= IDLE;
                    pix_cnt <= '0;
                    if (in_init)
                        init_cnt <= init_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

    abs_diff_thr #(
        .N_FACTOR (N_FACTOR)
    ) u_diff (
        .clk        (clk),
        .rst        (rst),
        .load       (take),
        .curr_pixel (bus.curr_pixel),
        .background (bus.background),
        .variance   (bus.variance),
        .diff       (diff),
        .thr        (thr)
    );

    // A frame-start pixel restarts the sum, which is how a short frame's partial count is dropped.
    assign nacc = (s2_first ? '0 : acc) + CNT_W'(mask_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sup   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            mask_q   <= 1'b0;
            acc      <= '0;
            count_q  <= '0;
            det_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            vld_pipe[0] <= take;
            vld_pipe[1] <= vld_pipe[0] && bus.enable;
            if (take) begin
                s1_first <= start;
                s1_last  <= last_pix;
                s1_sup   <= in_init;
            end
            s2_first <= s1_first;
            s2_last  <= s1_last;
            mask_q   <= vld_pipe[0] && bus.enable && !s1_sup && ({2'b00, diff} > thr);
            if (vld_pipe[1] && bus.enable) begin
                if (s2_last) begin
                    count_q <= nacc;
                    det_q   <= nacc >= CNT_W'(MIN_MOTION);
                    done_q  <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= nacc;
                end
            end
        end
    end

    assign bus.mask_valid      = vld_pipe[1];
    assign bus.mask_bit        = mask_q;
    assign bus.frame_done      = done_q;
    assign bus.motion_count    = count_q;
    assign bus.motion_detected = det_q;
    assign bus.frame_err       = err_q;

endmodule

// File: tb/tb_motion_mask.sv
// Scoreboard bench for motion_mask: two instances (INIT 0/MIN 3 and INIT 1/MIN 4) on a 4x2 frame
// share one directed stimulus stream; expected mask/frame/error events carry their due cycle.
module tb_motion_mask;
    import motion_pkg::*;

    typedef struct { int cyc; logic m; }           mexp_t;
    typedef struct { int cyc; int cnt; logic det; } fexp_t;
    typedef struct { int cyc; int held; }          eexp_t;

    logic clk = 0, rst = 0, enable = 1, in_valid = 0, in_sof = 0;
    pix_t cur = 0, bg = 0, vr = 0;
    int   cyc = 0, lastk = 0, n_pass = 0, n_total = 0;

    mexp_t mq[2][$];
    fexp_t fq[2][$];
    eexp_t eq[2][$];

    localparam int H = 0, P = 1, E = 2;
    // H: all motion; P: diffs 0,20,21,30,0,0,25,20 at var 10; E: arithmetic edges
    pix_t t_cur[3][8] = '{'{200, 10, 200, 10, 200, 10, 200, 10},
                          '{100, 80, 121, 70, 100, 100, 125, 80},
                          '{0, 0, 50, 51, 200, 0, 255, 0}};
    pix_t t_bg[3][8]  = '{'{10, 200, 10, 200, 10, 200, 10, 200},
                          '{100, 100, 100, 100, 100, 100, 100, 100},
                          '{255, 255, 50, 50, 0, 201, 0, 129}};
    pix_t t_var[3][8] = '{'{3, 3, 3, 3, 3, 3, 3, 3},
                          '{10, 10, 10, 10, 10, 10, 10, 10},
                          '{127, 128, 0, 0, 100, 100, 255, 64}};
    logic t_m[3][8]   = '{'{1, 1, 1, 1, 1, 1, 1, 1},
                          '{0, 0, 1, 1, 0, 0, 1, 0},
                          '{1, 0, 0, 1, 0, 1, 0, 1}};

    motion_mask_if #(.CNT_W(4)) bus_a ();
    motion_mask_if #(.CNT_W(4)) bus_b ();

    assign bus_a.enable = enable;   assign bus_b.enable = enable;
    assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
    assign bus_a.in_sof = in_sof;   assign bus_b.in_sof = in_sof;
    assign bus_a.curr_pixel = cur;  assign bus_b.curr_pixel = cur;
    assign bus_a.background = bg;   assign bus_b.background = bg;
    assign bus_a.variance = vr;     assign bus_b.variance = vr;

    motion_mask #(.N_FACTOR(2), .FRAME_W(4), .FRAME_H(2), .MIN_MOTION(3), .INIT_FRAMES(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    motion_mask #(.N_FACTOR(2), .FRAME_W(4), .FRAME_H(2), .MIN_MOTION(4), .INIT_FRAMES(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon(input int d, input logic mv, input logic mb, input logic fd,
                       input logic [3:0] mc, input logic md, input logic fe);
        mexp_t m; fexp_t f; eexp_t e;
        string p = $sformatf("dut%0d", d);
        if (mv) begin
            if (mq[d].size() == 0) chk({p, ".mask_valid_unexpected"}, 1, 0);
            else begin
                m = mq[d].pop_front();
                chk({p, ".mask_bit"}, mb, m.m);
                chk({p, ".mask_cycle"}, cyc, m.cyc);
            end
        end else if (mq[d].size() > 0 && mq[d][0].cyc <= cyc) begin
            m = mq[d].pop_front();
            chk({p, ".mask_missing_at"}, cyc, m.cyc - 1);
        end
        if (fd) begin
            if (fq[d].size() == 0) chk({p, ".frame_done_unexpected"}, 1, 0);
            else begin
                f = fq[d].pop_front();
                chk({p, ".motion_count"}, mc, f.cnt);
                chk({p, ".motion_detected"}, md, f.det);
                chk({p, ".frame_done_cycle"}, cyc, f.cyc);
            end
        end else if (fq[d].size() > 0 && fq[d][0].cyc <= cyc) begin
            f = fq[d].pop_front();
            chk({p, ".frame_done_missing_at"}, cyc, f.cyc - 1);
        end
        if (fe) begin
            if (eq[d].size() == 0) chk({p, ".frame_err_unexpected"}, 1, 0);
            else begin
                e = eq[d].pop_front();
                chk({p, ".count_held_on_err"}, mc, e.held);
                chk({p, ".frame_err_cycle"}, cyc, e.cyc);
            end
        end else if (eq[d].size() > 0 && eq[d][0].cyc <= cyc) begin
            e = eq[d].pop_front();
            chk({p, ".frame_err_missing_at"}, cyc, e.cyc - 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus_a.mask_valid, bus_a.mask_bit, bus_a.frame_done,
                bus_a.motion_count, bus_a.motion_detected, bus_a.frame_err);
            mon(1, bus_b.mask_valid, bus_b.mask_bit, bus_b.frame_done,
                bus_b.motion_count, bus_b.motion_detected, bus_b.frame_err);
        end
    end

    task automatic drive(input logic sof, input pix_t c, input pix_t b, input pix_t v);
        @(posedge clk); #1;
        enable = 1; in_valid = 1; in_sof = sof; cur = c; bg = b; vr = v;
        lastk = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        enable = 1; in_valid = 0; in_sof = 0;
    endtask

    task automatic pixel(input int f, input int i, input logic sof, input logic supb);
        mexp_t m;
        drive(sof, t_cur[f][i], t_bg[f][i], t_var[f][i]);
        m.cyc = lastk + 2; m.m = t_m[f][i];
        mq[0].push_back(m);
        m.m = supb ? 1'b0 : t_m[f][i];
        mq[1].push_back(m);
    endtask

    task automatic push_f(input int ca, input logic da, input int cb, input logic db);
        fexp_t f;
        f.cyc = lastk + 3; f.cnt = ca; f.det = da; fq[0].push_back(f);
        f.cnt = cb; f.det = db; fq[1].push_back(f);
    endtask

    task automatic push_e(input int ha, input int hb);
        eexp_t e;
        e.cyc = lastk + 1; e.held = ha; eq[0].push_back(e);
        e.held = hb; eq[1].push_back(e);
    endtask

    task automatic frame(input int f, input logic supb, input int ca, input logic da,
                         input int cb, input logic db);
        for (int i = 0; i < 8; i++) pixel(f, i, i == 0, supb);
        push_f(ca, da, cb, db);
    endtask

    task automatic chk_zero(input string p, input logic mv, input logic mb, input logic fd,
                            input logic [3:0] mc, input logic md, input logic fe);
        chk({p, ".rst_mask_valid"}, mv, 0);
        chk({p, ".rst_mask_bit"}, mb, 0);
        chk({p, ".rst_frame_done"}, fd, 0);
        chk({p, ".rst_motion_count"}, mc, 0);
        chk({p, ".rst_motion_detected"}, md, 0);
        chk({p, ".rst_frame_err"}, fe, 0);
    endtask

    initial begin
        #1 rst = 1;
        #2;
        chk_zero("dut0", bus_a.mask_valid, bus_a.mask_bit, bus_a.frame_done,
                 bus_a.motion_count, bus_a.motion_detected, bus_a.frame_err);
        chk_zero("dut1", bus_b.mask_valid, bus_b.mask_bit, bus_b.frame_done,
                 bus_b.motion_count, bus_b.motion_detected, bus_b.frame_err);
        #19 rst = 0;

        // back-to-back frames: init suppression on dut1, then MIN_MOTION 3 vs 4
        frame(H, 1, 8, 1, 0, 0);
        frame(H, 0, 8, 1, 8, 1);
        frame(P, 0, 3, 1, 3, 0);

        // short frame of 5 pixels, then an edge-arithmetic frame started by the offending SOF
        for (int i = 0; i < 5; i++) pixel(H, i, i == 0, 0);
        pixel(E, 0, 1, 0);
        push_e(3, 3);
        for (int i = 1; i < 8; i++) pixel(E, i, 0, 0);
        push_f(4, 1, 4, 1);
        idle();

        // pixels before SOF are dropped
        for (int i = 0; i < 3; i++) drive(0, t_cur[H][i], t_bg[H][i], t_var[H][i]);
        // P frame with a drain gap and 3 disabled cycles (one carrying SOF) mid-frame
        for (int i = 0; i < 4; i++) pixel(P, i, i == 0, 0);
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            enable = 0; in_valid = 1; in_sof = (i == 1); cur = 250; bg = 0; vr = 0;
        end
        for (int i = 4; i < 8; i++) pixel(P, i, 0, 0);
        push_f(3, 1, 3, 0);
        repeat (6) idle();

        // async reset while pixels are in flight
        for (int i = 0; i < 3; i++) pixel(H, i, i == 0, 0);
        @(posedge clk); #1;
        in_valid = 0; in_sof = 0;
        chk("dut0.mask_valid_before_rst", bus_a.mask_valid, 1);
        chk("dut0.motion_count_before_rst", bus_a.motion_count, 3);
        #1 rst = 1;
        #1;
        chk_zero("dut0", bus_a.mask_valid, bus_a.mask_bit, bus_a.frame_done,
                 bus_a.motion_count, bus_a.motion_detected, bus_a.frame_err);
        chk_zero("dut1", bus_b.mask_valid, bus_b.mask_bit, bus_b.frame_done,
                 bus_b.motion_count, bus_b.motion_detected, bus_b.frame_err);
        for (int d = 0; d < 2; d++) begin
            mq[d].delete(); fq[d].delete(); eq[d].delete();
        end
        repeat (2) @(posedge clk);
        #3 rst = 0;

        // init suppression restarts after reset
        frame(H, 1, 8, 1, 0, 0);
        repeat (8) idle();

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.mask_queue_left", d), mq[d].size(), 0);
            chk($sformatf("dut%0d.frame_queue_left", d), fq[d].size(), 0);
            chk($sformatf("dut%0d.err_queue_left", d), eq[d].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
